// File: rtl/forney_frame_sched.sv
// Forney frame scheduler: sequences sigma load, Chien sweep, Forney drain,
// flush and per-codeword status reporting for the RS decoder back end.
module forney_frame_sched #(
   parameter int T        = 11,
   parameter int CNT_W    = 4,
   parameter int TO_W     = 7,
   parameter int DRAIN_TO = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             rbm_vld_i,
   output logic             rbm_rdy_o,
   input  logic [CNT_W-1:0] rbm_deg_i,
   input  logic             rbm_fail_i,
   output logic             cfg_load_o,
   output logic             chien_start_o,
   input  logic             chien_done_i,
   input  logic             fy_vld_i,
   input  logic             fy_rdy_i,
   input  logic             fy_den_zero_i,
   input  logic             abort_i,
   output logic             flush_o,
   output logic             done_vld_o,
   input  logic             done_rdy_i,
   output logic [CNT_W-1:0] done_cnt_o,
   output logic             done_fail_o
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_SWEEP  = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_FLUSH  = 3'd4;
   localparam logic [2:0] S_REPORT = 3'd5;

   localparam logic [CNT_W-1:0] T_C    = CNT_W'(T);
   localparam logic [TO_W-1:0]  TO_MAX = TO_W'(DRAIN_TO - 1);

   logic [2:0]       state, state_nx;
   logic [CNT_W-1:0] deg_q, deg_nx;
   logic [CNT_W-1:0] cnt_q, cnt_nx, cnt_fire;
   logic [TO_W-1:0]  to_q, to_nx;
   logic             fail_q, fail_nx;
   logic             dz_q, dz_nx, dz_fire;
   logic             abt_q, abt_nx;
   logic             accept, fire, counting;

   assign accept   = rbm_vld_i & rbm_rdy_o;
   assign fire     = fy_vld_i & fy_rdy_i;
   assign counting = (state == S_SWEEP) | (state == S_DRAIN);

   // Hit count and den-zero flag as they stand including this cycle's fire
   always_comb begin
      cnt_fire = cnt_q;
      dz_fire  = dz_q;
      if (counting & fire) begin
         if (cnt_q != '1)
            cnt_fire = cnt_q + 1'b1;
         dz_fire = dz_q | fy_den_zero_i;
      end
   end

   // Next-state and datapath update logic
   always_comb begin
      state_nx = state;
      deg_nx   = deg_q;
      cnt_nx   = cnt_fire;
      dz_nx    = dz_fire;
      to_nx    = to_q;
      fail_nx  = fail_q;
      abt_nx   = abt_q;
      case (state)
         S_IDLE: begin
            if (accept) begin
               deg_nx  = rbm_deg_i;
               cnt_nx  = '0;
               dz_nx   = 1'b0;
               abt_nx  = 1'b0;
               fail_nx = 1'b0;
               if (rbm_fail_i || (rbm_deg_i > T_C)) begin
                  fail_nx  = 1'b1;
                  state_nx = S_FLUSH;
               end else if (rbm_deg_i == '0) begin
                  state_nx = S_REPORT;
               end else begin
                  state_nx = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            cnt_nx = '0;
            dz_nx  = 1'b0;
            if (abort_i) begin
               abt_nx   = 1'b1;
               state_nx = S_FLUSH;
            end else begin
               state_nx = S_SWEEP;
            end
         end
         S_SWEEP: begin
            if (abort_i) begin
               abt_nx   = 1'b1;
               state_nx = S_FLUSH;
            end else if (chien_done_i) begin
               to_nx    = '0;
               state_nx = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (abort_i) begin
               abt_nx   = 1'b1;
               state_nx = S_FLUSH;
            end else if ((cnt_fire == deg_q) && !dz_fire) begin
               fail_nx  = 1'b0;
               state_nx = S_REPORT;
            end else if ((cnt_fire > deg_q) || dz_fire) begin
               fail_nx  = 1'b1;
               state_nx = S_FLUSH;
            end else if (to_q == TO_MAX) begin
               fail_nx  = 1'b1;
               state_nx = S_FLUSH;
            end else begin
               to_nx = to_q + 1'b1;
            end
         end
         S_FLUSH: begin
            state_nx = abt_q ? S_IDLE : S_REPORT;
         end
         S_REPORT: begin
            if (abort_i) begin
               abt_nx   = 1'b1;
               state_nx = S_FLUSH;
            end else if (done_rdy_i) begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // State and datapath registers, cleared by asynchronous reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state  <= S_IDLE;
         deg_q  <= '0;
         cnt_q  <= '0;
         to_q   <= '0;
         fail_q <= 1'b0;
         dz_q   <= 1'b0;
         abt_q  <= 1'b0;
      end else begin
         state  <= state_nx;
         deg_q  <= deg_nx;
         cnt_q  <= cnt_nx;
         to_q   <= to_nx;
         fail_q <= fail_nx;
         dz_q   <= dz_nx;
         abt_q  <= abt_nx;
      end
   end

   assign rbm_rdy_o     = (state == S_IDLE) & ~rst_i;
   assign cfg_load_o    = (state == S_LOAD);
   assign chien_start_o = (state == S_LOAD);
   assign flush_o       = (state == S_FLUSH);
   assign done_vld_o    = (state == S_REPORT);
   assign done_cnt_o    = cnt_q;
   assign done_fail_o   = fail_q;

endmodule

// File: tb/tb_forney_frame_sched.sv
// Directed bench for forney_frame_sched: success, coincident fire,
// timeout, L>T, L=0, den-zero, abort, saturation, hold and reset.
module tb_forney_frame_sched;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       rbm_vld_i = 1'b0;
   logic       rbm_rdy_o;
   logic [3:0] rbm_deg_i = '0;
   logic       rbm_fail_i = 1'b0;
   logic       cfg_load_o;
   logic       chien_start_o;
   logic       chien_done_i = 1'b0;
   logic       fy_vld_i = 1'b0;
   logic       fy_rdy_i = 1'b0;
   logic       fy_den_zero_i = 1'b0;
   logic       abort_i = 1'b0;
   logic       flush_o;
   logic       done_vld_o;
   logic       done_rdy_i = 1'b0;
   logic [3:0] done_cnt_o;
   logic       done_fail_o;

   int n_chk = 0;
   int n_pass = 0;
   int n_flush = 0, n_load = 0, n_start = 0, n_done = 0, n_dbl = 0;
   logic p_fl = 1'b0, p_ld = 1'b0, p_st = 1'b0;

   forney_frame_sched dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .rbm_vld_i     (rbm_vld_i),
      .rbm_rdy_o     (rbm_rdy_o),
      .rbm_deg_i     (rbm_deg_i),
      .rbm_fail_i    (rbm_fail_i),
      .cfg_load_o    (cfg_load_o),
      .chien_start_o (chien_start_o),
      .chien_done_i  (chien_done_i),
      .fy_vld_i      (fy_vld_i),
      .fy_rdy_i      (fy_rdy_i),
      .fy_den_zero_i (fy_den_zero_i),
      .abort_i       (abort_i),
      .flush_o       (flush_o),
      .done_vld_o    (done_vld_o),
      .done_rdy_i    (done_rdy_i),
      .done_cnt_o    (done_cnt_o),
      .done_fail_o   (done_fail_o)
   );

   always #5 clk_i = ~clk_i;

   // Pulse counters and back-to-back pulse detector
   always @(posedge clk_i) begin
      if (flush_o) n_flush++;
      if (cfg_load_o) n_load++;
      if (chien_start_o) n_start++;
      if (done_vld_o) n_done++;
      if ((flush_o && p_fl) || (cfg_load_o && p_ld) || (chien_start_o && p_st))
         n_dbl++;
      p_fl = flush_o;
      p_ld = cfg_load_o;
      p_st = chien_start_o;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic accept(input logic [3:0] l, input logic f);
      chk("rdy_before_accept", 32'(rbm_rdy_o), 32'd1);
      rbm_vld_i  = 1'b1;
      rbm_deg_i  = l;
      rbm_fail_i = f;
      tick();
      rbm_vld_i  = 1'b0;
      rbm_fail_i = 1'b0;
   endtask

   task automatic do_fire(input logic dz, input logic done);
      fy_vld_i      = 1'b1;
      fy_rdy_i      = 1'b1;
      fy_den_zero_i = dz;
      chien_done_i  = done;
      tick();
      fy_vld_i      = 1'b0;
      fy_rdy_i      = 1'b0;
      fy_den_zero_i = 1'b0;
      chien_done_i  = 1'b0;
   endtask

   task automatic sweep_done();
      chien_done_i = 1'b1;
      tick();
      chien_done_i = 1'b0;
   endtask

   task automatic take_report(input string tag, input logic [3:0] c, input logic f);
      int k;
      k = 0;
      while (!done_vld_o && k < 200) begin
         tick();
         k++;
      end
      chk({tag, "_vld"}, 32'(done_vld_o), 32'd1);
      chk({tag, "_cnt"}, 32'(done_cnt_o), 32'(c));
      chk({tag, "_fail"}, 32'(done_fail_o), 32'(f));
      done_rdy_i = 1'b1;
      tick();
      done_rdy_i = 1'b0;
      chk({tag, "_idle"}, 32'(rbm_rdy_o), 32'd1);
   endtask

   initial begin
      int fl0, ld0, st0, dn0, k;
      // reset state
      #2;
      chk("rst_rdy", 32'(rbm_rdy_o), 32'd0);
      chk("rst_outs", 32'({cfg_load_o, chien_start_o, flush_o, done_vld_o, done_fail_o, done_cnt_o}), 32'd0);
      tick(); tick();
      rst_i = 1'b0;
      tick();
      chk("rel_rdy", 32'(rbm_rdy_o), 32'd1);

      // L=3, three fires, done -> DRAIN -> REPORT next cycle
      fl0 = n_flush;
      accept(4'd3, 1'b0);
      chk("load_pulse", 32'({cfg_load_o, chien_start_o}), 32'd3);
      tick();
      chk("load_one_cycle", 32'(cfg_load_o), 32'd0);
      for (int i = 0; i < 3; i++) do_fire(1'b0, 1'b0);
      sweep_done();
      chk("drain_no_vld", 32'(done_vld_o), 32'd0);
      tick();
      chk("report_next", 32'(done_vld_o), 32'd1);
      take_report("l3", 4'd3, 1'b0);
      chk("l3_no_flush", 32'(n_flush - fl0), 32'd0);

      // L=2, second fire coincident with chien_done
      accept(4'd2, 1'b0);
      tick();
      do_fire(1'b0, 1'b0);
      do_fire(1'b0, 1'b1);
      tick();
      chk("coinc_vld", 32'(done_vld_o), 32'd1);
      take_report("l2", 4'd2, 1'b0);

      // L=4, two fires, timeout
      accept(4'd4, 1'b0);
      tick();
      do_fire(1'b0, 1'b0);
      do_fire(1'b0, 1'b0);
      sweep_done();
      k = 0;
      while (!flush_o && k < 200) begin
         tick();
         k++;
      end
      chk("to_cycles", 32'(k), 32'd64);
      take_report("to", 4'd2, 1'b1);

      // L > T: straight to FLUSH, no load
      ld0 = n_load;
      st0 = n_start;
      accept(4'd12, 1'b0);
      chk("big_flush", 32'(flush_o), 32'd1);
      take_report("big", 4'd0, 1'b1);
      chk("big_no_load", 32'(n_load - ld0), 32'd0);
      chk("big_no_start", 32'(n_start - st0), 32'd0);

      // solver fail flag
      accept(4'd5, 1'b1);
      chk("sfail_flush", 32'(flush_o), 32'd1);
      take_report("sfail", 4'd0, 1'b1);

      // L=0: report immediately, no sweep
      st0 = n_start;
      fl0 = n_flush;
      accept(4'd0, 1'b0);
      chk("l0_vld", 32'(done_vld_o), 32'd1);
      take_report("l0", 4'd0, 1'b0);
      chk("l0_no_sweep", 32'(n_start - st0 + n_flush - fl0), 32'd0);

      // den-zero fire -> flush, fail
      accept(4'd2, 1'b0);
      tick();
      do_fire(1'b1, 1'b0);
      sweep_done();
      tick();
      chk("dz_flush", 32'(flush_o), 32'd1);
      take_report("dz", 4'd1, 1'b1);

      // count beyond L with saturation
      accept(4'd11, 1'b0);
      tick();
      for (int i = 0; i < 17; i++) do_fire(1'b0, 1'b0);
      sweep_done();
      tick();
      chk("sat_flush", 32'(flush_o), 32'd1);
      take_report("sat", 4'd15, 1'b1);

      // abort during SWEEP
      fl0 = n_flush;
      dn0 = n_done;
      accept(4'd3, 1'b0);
      tick();
      do_fire(1'b0, 1'b0);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      chk("abt_flush", 32'(flush_o), 32'd1);
      tick();
      chk("abt_idle", 32'(rbm_rdy_o), 32'd1);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      tick(); tick();
      chk("abt_one_flush", 32'(n_flush - fl0), 32'd1);
      chk("abt_no_done", 32'(n_done - dn0), 32'd0);

      // REPORT held with done_rdy low; fires ignored
      accept(4'd1, 1'b0);
      tick();
      do_fire(1'b0, 1'b1);
      tick();
      fy_vld_i = 1'b1;
      fy_rdy_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("hold", 32'({done_vld_o, done_cnt_o, done_fail_o}), 32'b1_0001_0);
         tick();
      end
      fy_vld_i = 1'b0;
      fy_rdy_i = 1'b0;
      take_report("hold_rel", 4'd1, 1'b0);

      // reset asserted in DRAIN
      accept(4'd3, 1'b0);
      tick();
      do_fire(1'b0, 1'b0);
      sweep_done();
      fl0 = n_flush;
      dn0 = n_done;
      rst_i = 1'b1;
      #1;
      chk("mrst_rdy", 32'(rbm_rdy_o), 32'd0);
      chk("mrst_outs", 32'({cfg_load_o, chien_start_o, flush_o, done_vld_o, done_fail_o, done_cnt_o}), 32'd0);
      tick();
      rst_i = 1'b0;
      tick();
      chk("mrst_rel_rdy", 32'(rbm_rdy_o), 32'd1);
      for (int i = 0; i < 5; i++) tick();
      chk("mrst_discard", 32'(n_flush - fl0 + n_done - dn0), 32'd0);

      chk("no_back_to_back", 32'(n_dbl), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/forney_frame_sched.md
FORNEY_FRAME_SCHED -- requirements
Module: forney_frame_sched

Interface
REQ-001 Parameters: T, default 11, max correctable symbols; CNT_W, default 4, error-count width (2^CNT_W > T); TO_W, default 7, drain-timeout counter width; DRAIN_TO, default 64, drain timeout cycles (< 2^TO_W).
REQ-002 Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- rbm_vld_i  in  1  key-equation result valid
- rbm_rdy_o  out  1  scheduler accepts a new codeword
- rbm_deg_i  in  CNT_W  sigma degree L
- rbm_fail_i  in  1  key-equation solver reports uncorrectable
- cfg_load_o  out  1  one-cycle pulse loading sigma/v into Forney S1
- chien_start_o  out  1  one-cycle pulse starting the Chien sweep
- chien_done_i  in  1  one-cycle pulse, sweep finished
- fy_vld_i, fy_rdy_i  in  1 each  observed Forney output handshake; fire = both high
- fy_den_zero_i  in  1  den_zero flag qualified by fire
- abort_i  in  1  synchronous abort request
- flush_o  out  1  one-cycle flush pulse to Forney
- done_vld_o  out  1  codeword status valid
- done_rdy_i  in  1  status consumer ready
- done_cnt_o  out  CNT_W  corrected-symbol count
- done_fail_o  out  1  codeword uncorrectable

Function
REQ-003 FSM states: IDLE, LOAD, SWEEP, DRAIN, FLUSH, REPORT; one-hot or binary encoding allowed.
REQ-004 rbm_rdy_o = 1 only in IDLE; acceptance = rbm_vld_i & rbm_rdy_o; on acceptance latch L = rbm_deg_i and rbm_fail_i.
REQ-005 IDLE on accept: fail or L > T -> FLUSH with fail flag set; L == 0 -> REPORT with cnt 0, fail 0, no sweep; otherwise -> LOAD.
REQ-006 LOAD lasts exactly one cycle: cfg_load_o = 1 and chien_start_o = 1 in that cycle, hit counter cleared to 0, den-zero flag cleared; next state SWEEP.
REQ-007 Hit counter increments by 1 on every fire in SWEEP and DRAIN; it saturates at 2^CNT_W-1 and does not wrap.
REQ-008 Any fire with fy_den_zero_i = 1 sets a sticky den-zero flag.
REQ-009 SWEEP -> DRAIN on chien_done_i; a fire in the same cycle is counted; timeout counter cleared on entry to DRAIN.
REQ-010 DRAIN, evaluated each cycle with the count including the current fire: count == L and den-zero flag clear -> REPORT, fail 0; count > L or den-zero flag set -> FLUSH, fail 1; timeout counter reaching DRAIN_TO-1 with count < L -> FLUSH, fail 1.
REQ-011 FLUSH lasts exactly one cycle with flush_o = 1; next state REPORT, except on abort (REQ-013).
REQ-012 REPORT: done_vld_o = 1 and done_cnt_o/done_fail_o held stable until done_vld_o & done_rdy_i; then IDLE. Fires in REPORT or IDLE are ignored and not counted.
REQ-013 abort_i = 1 in LOAD, SWEEP, DRAIN or REPORT -> FLUSH, then IDLE with no report; abort_i takes priority over all other transitions; abort_i is ignored in IDLE and FLUSH.
REQ-014 cfg_load_o, chien_start_o and flush_o are never high for two consecutive cycles.
REQ-015 done_cnt_o = hit count on success, latched L... no: done_cnt_o = hit count in every REPORT; on fail paths from IDLE it is 0.

Reset
REQ-016 rst_i = 1 asynchronously forces IDLE, clears all counters and flags, and drives every output to 0 except rbm_rdy_o = 1 after release.
REQ-017 Reset asserted mid-codeword discards the codeword; no flush_o or done_vld_o is generated for it.

Verification
REQ-018 L=3, three fires during SWEEP, chien_done -> DRAIN then REPORT next cycle with cnt=3, fail=0, flush_o never pulsed.
REQ-019 L=2, one fire in SWEEP, one fire coincident with chien_done -> REPORT cnt=2, fail=0.
REQ-020 L=4, two fires, chien_done, nothing for 64 cycles -> flush_o pulse on the cycle after the timeout cycle, then REPORT cnt=2, fail=1.
REQ-021 rbm_deg_i=12 (L > T) -> no cfg_load_o or chien_start_o; FLUSH then REPORT cnt=0, fail=1; L=0 -> REPORT cnt=0, fail=0 with no sweep.
REQ-022 L=2, one fire with fy_den_zero_i=1 -> REPORT fail=1 after flush; in a separate run, abort_i during SWEEP -> one flush_o, return to IDLE, done_vld_o never asserted.
REQ-023 done_rdy_i held low for 10 cycles in REPORT -> done_vld_o and payload stable for all 10 cycles; rst_i pulsed in DRAIN -> all outputs 0 immediately and rbm_rdy_o=1 after release.
